mux_ctrl_rr: RTL and testbench

- Per-output-port switch controller for the shared-memory crossbar. It is the parametrised successor of the fixed-priority output mux controller.
- For each of PORT_NUB output ports, it selects one of PORT_NUB requesting input ports and drives that output's write enable and mux select.
- Adds three capabilities:
  - round-robin or fixed-priority arbitration, chosen by a mode parameter;
  - packet lock, so a granted source keeps the output until its last beat;
  - a stall timeout that force-releases a hung lock.
- Sits between the input-port request decoders and the per-output write muxes of the shared cache.

---
 rtl/mux_ctrl_rr_pkg.sv | 14 +
 rtl/mux_ctrl_rr_arb.sv | 127 ++++++++++++
 rtl/mux_ctrl_rr.sv | 52 +++++
 tb/tb_mux_ctrl_rr.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/mux_ctrl_rr_pkg.sv
// Shared constants and state encoding for the crossbar output-mux controller.
package mux_ctrl_rr_pkg;

  localparam int PORT_NUB_TOTAL      = 4;
  localparam int ARB_MODE_FIXED      = 0;
  localparam int ARB_MODE_RR         = 1;
  localparam int MUXCTRL_TIMEOUT_DEF = 16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mux_ctrl_rr_arb.sv
// One output channel: source pick, packet lock, round-robin pointer and stall timeout.
module mux_ctrl_rr_arb
  import mux_ctrl_rr_pkg::*;
#(
  parameter int PORT_NUB  = PORT_NUB_TOTAL,
  parameter int WIDTH_SEL = (PORT_NUB > 1) ? $clog2(PORT_NUB) : 1,
  parameter int ARB_MODE  = ARB_MODE_RR,
  parameter int LOCK_EN   = 1,
  parameter int TIMEOUT   = MUXCTRL_TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PORT_NUB-1:0]  vld,
  input  logic [PORT_NUB-1:0]  last,
  output logic                 wr_en,
  output logic [WIDTH_SEL-1:0] sel,
  output logic [PORT_NUB-1:0]  gnt,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int                 CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]      CNT_MAX  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [WIDTH_SEL-1:0] LAST_IDX = WIDTH_SEL'(PORT_NUB - 1);

  arb_state_e           state, state_nxt;
  logic [WIDTH_SEL-1:0] owner, owner_nxt, ptr, ptr_nxt;
  logic [WIDTH_SEL-1:0] pick, lo, winner;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic                 terr_nxt, hit, take, rel;

  // Wrap is modulo PORT_NUB, which need not be a power of two.
  function automatic logic [WIDTH_SEL-1:0] wrap_inc(input logic [WIDTH_SEL-1:0] x);
    return (x == LAST_IDX) ? '0 : x + 1'b1;
  endfunction

  // Round-robin: lowest valid index >= ptr, else lowest valid overall (the wrap).
  always_comb begin
    pick = '0;
    lo   = '0;
    hit  = 1'b0;
    if (ARB_MODE == ARB_MODE_FIXED) begin
      for (int j = 0; j < PORT_NUB; j++)
        if (vld[j]) pick = WIDTH_SEL'(j);
    end else begin
      for (int j = PORT_NUB - 1; j >= 0; j--) begin
        if (vld[j]) begin
          lo = WIDTH_SEL'(j);
          if (WIDTH_SEL'(j) >= ptr) begin
            pick = WIDTH_SEL'(j);
            hit  = 1'b1;
          end
        end
      end
      if (!hit) pick = lo;
    end
  end

  assign winner = (state == ST_BUSY) ? owner : pick;
  assign take   = vld[winner];
  assign busy   = (state == ST_BUSY);

  // Data-path controls are combinational and forced low while reset is held.
  always_comb begin
    wr_en       = rst_n & take;
    sel         = rst_n ? winner : '0;
    gnt         = '0;
    gnt[winner] = wr_en;
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    terr_nxt  = 1'b0;
    rel       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (take) begin
          if ((LOCK_EN != 0) && !last[winner]) begin
            state_nxt = ST_BUSY;
            owner_nxt = winner;
            cnt_nxt   = '0;
          end else begin
            rel = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (take) begin
          cnt_nxt = '0;
          if (last[winner]) begin
            state_nxt = ST_IDLE;
            rel       = 1'b1;
          end
        end else if ((TIMEOUT != 0) && (cnt == CNT_MAX)) begin
          state_nxt = ST_IDLE;
          terr_nxt  = 1'b1;
          cnt_nxt   = '0;
          if (ARB_MODE == ARB_MODE_RR) ptr_nxt = wrap_inc(owner);
        end else if (TIMEOUT != 0) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (rel && (ARB_MODE == ARB_MODE_RR)) ptr_nxt = wrap_inc(winner);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      owner       <= '0;
      ptr         <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      owner       <= owner_nxt;
      ptr         <= ptr_nxt;
      cnt         <= cnt_nxt;
      timeout_err <= terr_nxt;
    end
  end

endmodule

// File: rtl/mux_ctrl_rr.sv
// Crossbar output-mux controller: one independent arbiter per output port.
module mux_ctrl_rr
  import mux_ctrl_rr_pkg::*;
#(
  parameter int PORT_NUB  = PORT_NUB_TOTAL,
  parameter int WIDTH_SEL = (PORT_NUB > 1) ? $clog2(PORT_NUB) : 1,
  parameter int ARB_MODE  = ARB_MODE_RR,
  parameter int LOCK_EN   = 1,
  parameter int TIMEOUT   = MUXCTRL_TIMEOUT_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [PORT_NUB*PORT_NUB-1:0]  port_vaild,
  input  logic [PORT_NUB-1:0]           port_last,
  output logic [PORT_NUB-1:0]           wr_en_out,
  output logic [PORT_NUB*WIDTH_SEL-1:0] mux_sel,
  output logic [PORT_NUB*PORT_NUB-1:0]  grant,
  output logic [PORT_NUB-1:0]           out_busy,
  output logic [PORT_NUB-1:0]           timeout_err
);

  // Row i of each matrix belongs to output i; column j to input j.
  logic [PORT_NUB-1:0][PORT_NUB-1:0]  vld_mat, gnt_mat;
  logic [PORT_NUB-1:0][WIDTH_SEL-1:0] sel_mat;

  assign vld_mat = port_vaild;
  assign grant   = gnt_mat;
  assign mux_sel = sel_mat;

  generate
    for (genvar i = 0; i < PORT_NUB; i++) begin : g_out
      mux_ctrl_rr_arb #(
        .PORT_NUB (PORT_NUB),
        .WIDTH_SEL(WIDTH_SEL),
        .ARB_MODE (ARB_MODE),
        .LOCK_EN  (LOCK_EN),
        .TIMEOUT  (TIMEOUT)
      ) u_arb (
        .clk        (clk),
        .rst_n      (rst_n),
        .vld        (vld_mat[i]),
        .last       (port_last),
        .wr_en      (wr_en_out[i]),
        .sel        (sel_mat[i]),
        .gnt        (gnt_mat[i]),
        .busy       (out_busy[i]),
        .timeout_err(timeout_err[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_mux_ctrl_rr.sv
// Directed vector bench for mux_ctrl_rr: round-robin, lock, timeout, fixed priority, reset.
module tb_mux_ctrl_rr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] port_vaild = '0;
  logic [3:0]  port_last = '0;
  logic [3:0]  wr_en_out, out_busy, timeout_err;
  logic [7:0]  mux_sel;
  logic [15:0] grant;
  logic [3:0]  fx_wr, fx_busy, fx_terr;
  logic [7:0]  fx_sel;
  logic [15:0] fx_gnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_ctrl_rr #(.PORT_NUB(4), .ARB_MODE(1), .LOCK_EN(1), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .port_vaild(port_vaild), .port_last(port_last),
    .wr_en_out(wr_en_out), .mux_sel(mux_sel), .grant(grant),
    .out_busy(out_busy), .timeout_err(timeout_err)
  );

  mux_ctrl_rr #(.PORT_NUB(4), .ARB_MODE(0), .LOCK_EN(1), .TIMEOUT(4)) dut_fix (
    .clk(clk), .rst_n(rst_n), .port_vaild(port_vaild), .port_last(port_last),
    .wr_en_out(fx_wr), .mux_sel(fx_sel), .grant(fx_gnt),
    .out_busy(fx_busy), .timeout_err(fx_terr)
  );

  typedef struct {
    string       name;
    logic [15:0] vld;
    logic [3:0]  last;
    logic [3:0]  wr;
    logic [7:0]  sel;
    logic [15:0] gnt;
    logic [3:0]  busy;
    logic [3:0]  terr;
  } vec_t;

  vec_t tbl [17];

  logic [7:0]  e_sel [3] = '{8'h00, 8'h40, 8'h80};
  logic [15:0] e_gnt [3] = '{16'h1000, 16'h2000, 16'h4000};

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] wr, input logic [7:0] sel,
                         input logic [15:0] gnt, input logic [3:0] busy, input logic [3:0] terr);
    chk({nm, ".wr"},   16'(wr_en_out),   16'(wr));
    chk({nm, ".sel"},  16'(mux_sel),     16'(sel));
    chk({nm, ".gnt"},  grant,            gnt);
    chk({nm, ".busy"}, 16'(out_busy),    16'(busy));
    chk({nm, ".terr"}, 16'(timeout_err), 16'(terr));
  endtask

  initial begin
    // Output 0: inputs 1 and 3, single-beat packets, must alternate.
    tbl[0]  = '{"rr_b1",   16'h000A, 4'hF, 4'h1, 8'h01, 16'h0002, 4'h0, 4'h0};
    tbl[1]  = '{"rr_b2",   16'h000A, 4'hF, 4'h1, 8'h03, 16'h0008, 4'h0, 4'h0};
    tbl[2]  = '{"rr_b3",   16'h000A, 4'hF, 4'h1, 8'h01, 16'h0002, 4'h0, 4'h0};
    tbl[3]  = '{"rr_b4",   16'h000A, 4'hF, 4'h1, 8'h03, 16'h0008, 4'h0, 4'h0};
    // Output 1: input 2 three-beat packet, input 0 joins on beat 2.
    tbl[4]  = '{"lock_c1", 16'h0040, 4'h1, 4'h2, 8'h08, 16'h0040, 4'h0, 4'h0};
    tbl[5]  = '{"lock_c2", 16'h0050, 4'h1, 4'h2, 8'h08, 16'h0040, 4'h2, 4'h0};
    tbl[6]  = '{"lock_c3", 16'h0050, 4'h5, 4'h2, 8'h08, 16'h0040, 4'h2, 4'h0};
    tbl[7]  = '{"lock_c4", 16'h0010, 4'h1, 4'h2, 8'h00, 16'h0010, 4'h0, 4'h0};
    // Output 2: owner 2 stalls once (counter clears), then stalls into the timeout.
    tbl[8]  = '{"to_d1",   16'h0400, 4'h0, 4'h4, 8'h20, 16'h0400, 4'h0, 4'h0};
    tbl[9]  = '{"to_d2",   16'h0000, 4'h0, 4'h0, 8'h20, 16'h0000, 4'h4, 4'h0};
    tbl[10] = '{"to_d3",   16'h0400, 4'h0, 4'h4, 8'h20, 16'h0400, 4'h4, 4'h0};
    tbl[11] = '{"to_d4",   16'h0000, 4'h0, 4'h0, 8'h20, 16'h0000, 4'h4, 4'h0};
    tbl[12] = '{"to_d5",   16'h0100, 4'h0, 4'h0, 8'h20, 16'h0000, 4'h4, 4'h0};
    tbl[13] = '{"to_d6",   16'h0000, 4'h0, 4'h0, 8'h20, 16'h0000, 4'h4, 4'h0};
    tbl[14] = '{"to_d7",   16'h0000, 4'h0, 4'h0, 8'h20, 16'h0000, 4'h4, 4'h0};
    tbl[15] = '{"to_d8",   16'h0000, 4'h0, 4'h0, 8'h00, 16'h0000, 4'h0, 4'h4};
    tbl[16] = '{"to_d9",   16'h0900, 4'hF, 4'h4, 8'h30, 16'h0800, 4'h0, 4'h0};

    #1;
    chk_all("reset", 4'h0, 8'h00, 16'h0000, 4'h0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_all($sformatf("idle%0d", c), 4'h0, 8'h00, 16'h0000, 4'h0, 4'h0);
      @(posedge clk); #1;
    end

    for (int k = 0; k < 17; k++) begin
      port_vaild = tbl[k].vld;
      port_last  = tbl[k].last;
      @(negedge clk);
      chk_all(tbl[k].name, tbl[k].wr, tbl[k].sel, tbl[k].gnt, tbl[k].busy, tbl[k].terr);
      @(posedge clk); #1;
    end

    // Inputs 0,1,2 to output 3: round-robin rotates, fixed priority always picks 2.
    port_vaild = 16'h7000;
    port_last  = 4'hF;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rr_e%0d.gnt", k), grant, e_gnt[k]);
      chk($sformatf("rr_e%0d.sel", k), 16'(mux_sel), 16'(e_sel[k]));
      chk($sformatf("fix_e%0d.sel", k), 16'(fx_sel), 16'h0080);
      chk($sformatf("fix_e%0d.gnt", k), fx_gnt, 16'h4000);
      chk($sformatf("fix_e%0d.wr", k), 16'(fx_wr), 16'h0008);
      @(posedge clk); #1;
    end

    // Reset mid-packet on output 1, then a fresh request with ptr back at 0.
    port_vaild = 16'h0040;
    port_last  = 4'h0;
    @(negedge clk);
    chk("rst_f1.wr", 16'(wr_en_out), 16'h0002);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_f2.busy", 16'(out_busy), 16'h0002);
    #2 rst_n = 1'b0;
    #1;
    chk_all("rst_f3", 4'h0, 8'h00, 16'h0000, 4'h0, 4'h0);
    chk("rst_f3.fix_busy", 16'(fx_busy), 16'h0000);
    port_vaild = 16'h0030;
    port_last  = 4'hF;
    @(posedge clk); #1;
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk_all("rst_f4", 4'h2, 8'h00, 16'h0010, 4'h0, 4'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_f5.gnt", grant, 16'h0020);
    chk("rst_f5.sel", 16'(mux_sel), 16'h0004);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
